noun_mem_responder: RTL and testbench

//  Responder end of the noun-memory request interface; the traversal FSM and the opcode modules are its initiators.

---
 rtl/noun_mem_responder.sv | 140 ++++++++++++++
 tb/tb_noun_mem_responder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noun_mem_responder.sv
// Noun-memory responder: owns the word array, serves dual-port reads, single writes and bump allocation.
// Latency: reads complete READ_LAT edges after capture, writes/allocates 1 edge; mem_ready pulses the cycle after.
// Backpressure: none; requests are accepted only in IDLE, strobes while busy are dropped and flagged in error[0].
module noun_mem_responder #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 16,
    parameter int READ_LAT   = 2,
    parameter int FREE_START = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_execute,
    input  logic [1:0]        mem_func,
    input  logic [ADDR_W-1:0] address1,
    input  logic [ADDR_W-1:0] address2,
    input  logic [DATA_W-1:0] write_data,
    output logic              mem_ready,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [ADDR_W-1:0] free_addr,
    output logic [7:0]        error
);

    localparam logic [1:0]        FUNC_NOP  = 2'd0;
    localparam logic [1:0]        FUNC_GET  = 2'd1;
    localparam logic [1:0]        FUNC_SET  = 2'd2;
    localparam logic [ADDR_W-1:0] NIL       = '1;
    localparam int                CNT_W     = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(READ_LAT - 1);

    typedef enum logic [1:0] {IDLE, RD, WR, AL} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] a1_q, a2_q;
    logic [DATA_W-1:0] wd_q;
    logic [2:0]        err_q;
    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic capture, rd_done, wr_done, al_done;
    logic busy_hit, nil1, nil2, al_full;

    assign busy_hit = mem_execute && (state_q != IDLE);
    assign nil1     = (a1_q == NIL);
    assign nil2     = (a2_q == NIL);
    assign al_full  = (free_addr == NIL);
    assign error    = {5'b0, err_q};

    // Next-state decode; the *_done strobes mark the completing edge of each request type.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        rd_done = 1'b0;
        wr_done = 1'b0;
        al_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_execute && mem_func != FUNC_NOP) begin
                    capture = 1'b1;
                    case (mem_func)
                        FUNC_GET: state_d = RD;
                        FUNC_SET: state_d = WR;
                        default:  state_d = AL;
                    endcase
                end
            end
            RD: begin
                if (cnt_q == CNT_LAST) begin
                    rd_done = 1'b1;
                    state_d = IDLE;
                end
            end
            WR: begin
                wr_done = 1'b1;
                state_d = IDLE;
            end
            AL: begin
                al_done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, read-latency counter and request capture (inputs may change after capture).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a1_q    <= '0;
            a2_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                cnt_q <= '0;
                a1_q  <= address1;
                a2_q  <= address2;
                wd_q  <= write_data;
            end else if (state_q == RD) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Completion outputs: ready pulse, read/allocate results, free pointer and sticky errors.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_ready  <= 1'b0;
            read_data1 <= '0;
            read_data2 <= '0;
            free_addr  <= ADDR_W'(FREE_START);
            err_q      <= '0;
        end else begin
            mem_ready <= rd_done || wr_done || al_done;
            if (rd_done) begin
                read_data1 <= nil1 ? '0 : mem[a1_q];
                read_data2 <= nil2 ? '0 : mem[a2_q];
            end
            if (al_done) begin
                // A full allocator reports NIL and stays parked there.
                read_data1 <= DATA_W'(free_addr);
                if (!al_full) free_addr <= free_addr + ADDR_W'(1);
            end
            if (busy_hit)                                      err_q[0] <= 1'b1;
            if ((rd_done && (nil1 || nil2)) || (wr_done && nil1)) err_q[1] <= 1'b1;
            if (al_done && al_full)                            err_q[2] <= 1'b1;
        end
    end

    // Array writes; the state reset above guarantees an aborted request never reaches this point.
    always_ff @(posedge clk) begin
        if (wr_done && !nil1) begin
            mem[a1_q] <= wd_q;
        end else if (al_done && !al_full) begin
            mem[free_addr] <= wd_q;
        end
    end

endmodule

// File: tb/tb_noun_mem_responder.sv
module tb_noun_mem_responder;

    localparam int AW  = 10;
    localparam int DW  = 16;
    localparam int LAT = 2;
    localparam logic [AW-1:0] NIL = '1;
    localparam logic [1:0] F_GET = 2'd1, F_SET = 2'd2, F_FREE = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          exec = 1'b0, sel_hi = 1'b0;
    logic [1:0]    func = '0;
    logic [AW-1:0] a1 = '0, a2 = '0;
    logic [DW-1:0] wd = '0;
    logic          exec_lo, exec_hi;
    logic          rdy_lo, rdy_hi, o_rdy;
    logic [DW-1:0] d1_lo, d2_lo, d1_hi, d2_hi, o_d1, o_d2;
    logic [AW-1:0] fa_lo, fa_hi, o_fa;
    logic [7:0]    err_lo, err_hi, o_err;

    assign exec_lo = exec && !sel_hi;
    assign exec_hi = exec && sel_hi;
    assign o_rdy   = sel_hi ? rdy_hi : rdy_lo;
    assign o_d1    = sel_hi ? d1_hi  : d1_lo;
    assign o_d2    = sel_hi ? d2_hi  : d2_lo;
    assign o_fa    = sel_hi ? fa_hi  : fa_lo;
    assign o_err   = sel_hi ? err_hi : err_lo;

    noun_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(LAT), .FREE_START(0)) dut (
        .clk(clk), .rst(rst), .mem_execute(exec_lo), .mem_func(func),
        .address1(a1), .address2(a2), .write_data(wd),
        .mem_ready(rdy_lo), .read_data1(d1_lo), .read_data2(d2_lo),
        .free_addr(fa_lo), .error(err_lo)
    );

    noun_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(LAT), .FREE_START(1022)) dut_hi (
        .clk(clk), .rst(rst), .mem_execute(exec_hi), .mem_func(func),
        .address1(a1), .address2(a2), .write_data(wd),
        .mem_ready(rdy_hi), .read_data1(d1_hi), .read_data2(d2_hi),
        .free_addr(fa_hi), .error(err_hi)
    );

    typedef struct {
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [AW-1:0] fa;
        logic [7:0]    err;
        int            lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_pass = 0;
    int   n_tot  = 0;

    // Behavioural model of the selected responder
    logic [DW-1:0] mem_m [1024];
    logic [DW-1:0] m_d1, m_d2;
    logic [AW-1:0] m_fa;
    logic [7:0]    m_err;

    // Observed results of the most recent request
    logic [DW-1:0] s_d1, s_d2;
    logic [AW-1:0] s_fa;
    logic [7:0]    s_err;
    int            s_lat;

    // Called and returns at a negedge; the next request is captured at the very next posedge.
    task automatic req(input logic [1:0] f, input logic [AW-1:0] x1, input logic [AW-1:0] x2,
                       input logic [DW-1:0] w, input bit poke);
        exp_t ex;
        if (poke) m_err[0] = 1'b1;
        case (f)
            F_GET: begin
                m_d1 = (x1 == NIL) ? '0 : mem_m[x1];
                m_d2 = (x2 == NIL) ? '0 : mem_m[x2];
                if (x1 == NIL || x2 == NIL) m_err[1] = 1'b1;
            end
            F_SET: begin
                if (x1 == NIL) m_err[1] = 1'b1;
                else mem_m[x1] = w;
            end
            F_FREE: begin
                m_d1 = DW'(m_fa);
                if (m_fa == NIL) m_err[2] = 1'b1;
                else begin
                    mem_m[m_fa] = w;
                    m_fa = m_fa + 1'b1;
                end
            end
            default: ;
        endcase
        ex.d1 = m_d1; ex.d2 = m_d2; ex.fa = m_fa; ex.err = m_err;
        ex.lat = (f == F_GET) ? LAT : 1;
        exp_q.push_back(ex);

        exec = 1'b1; func = f; a1 = x1; a2 = x2; wd = w;
        @(posedge clk);
        @(negedge clk);
        // Inputs are scrambled after capture; optionally keep strobing while busy.
        exec = poke; func = poke ? F_SET : 2'd0; a1 = '0; a2 = '0; wd = '0;
        s_lat = 0;
        while (!o_rdy && s_lat < 20) begin
            @(negedge clk);
            exec = 1'b0; func = '0;
            s_lat++;
        end
        if (!o_rdy) s_lat = -1;
        s_d1 = o_d1; s_d2 = o_d2; s_fa = o_fa; s_err = o_err;
    endtask

    task automatic do_reset(input logic [AW-1:0] fa0);
        @(negedge clk);
        rst = 1'b0; exec = 1'b0; func = '0; a1 = '0; a2 = '0; wd = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m_d1 = '0; m_d2 = '0; m_fa = fa0; m_err = '0;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset('0);
        n_tot++; if (o_rdy !== 1'b0)   $display("FAIL reset_rdy got %b exp 0", o_rdy);       else n_pass++;
        n_tot++; if (o_d1 !== '0)      $display("FAIL reset_rd1 got %h exp 0", o_d1);        else n_pass++;
        n_tot++; if (o_d2 !== '0)      $display("FAIL reset_rd2 got %h exp 0", o_d2);        else n_pass++;
        n_tot++; if (o_fa !== '0)      $display("FAIL reset_free got %0d exp 0", o_fa);      else n_pass++;
        n_tot++; if (o_err !== 8'h00)  $display("FAIL reset_err got %h exp 00", o_err);      else n_pass++;
        n_tot++; if (fa_hi !== 10'd1022) $display("FAIL reset_free_hi got %0d exp 1022", fa_hi); else n_pass++;
    endtask

    // Write then an immediate same-address read on both ports.
    task automatic test_write_read();
        for (int i = 0; i < 2; i++) begin
            case (i)
                0: req(F_SET, 10'd5, 10'd0, 16'hABC, 1'b0);
                default: req(F_GET, 10'd5, 10'd5, 16'h0, 1'b0);
            endcase
            e = exp_q.pop_front();
            n_tot++; if (s_lat !== e.lat) $display("FAIL wr_rd#%0d latency got %0d exp %0d", i, s_lat, e.lat); else n_pass++;
            n_tot++; if (s_d1 !== e.d1)   $display("FAIL wr_rd#%0d rd1 got %h exp %h", i, s_d1, e.d1);       else n_pass++;
            n_tot++; if (s_d2 !== e.d2)   $display("FAIL wr_rd#%0d rd2 got %h exp %h", i, s_d2, e.d2);       else n_pass++;
            n_tot++; if (s_fa !== e.fa)   $display("FAIL wr_rd#%0d free got %0d exp %0d", i, s_fa, e.fa);    else n_pass++;
            n_tot++; if (s_err !== e.err) $display("FAIL wr_rd#%0d err got %h exp %h", i, s_err, e.err);     else n_pass++;
        end
        n_tot++; if (s_d1 !== 16'hABC) $display("FAIL wr_rd_value got %h exp abc", s_d1); else n_pass++;
    endtask

    task automatic test_alloc();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: req(F_FREE, 10'd0, 10'd0, 16'h1111, 1'b0);
                1: req(F_FREE, 10'd0, 10'd0, 16'h2222, 1'b0);
                default: req(F_GET, 10'd0, 10'd1, 16'h0, 1'b0);
            endcase
            e = exp_q.pop_front();
            n_tot++; if (s_lat !== e.lat) $display("FAIL alloc#%0d latency got %0d exp %0d", i, s_lat, e.lat); else n_pass++;
            n_tot++; if (s_d1 !== e.d1)   $display("FAIL alloc#%0d rd1 got %h exp %h", i, s_d1, e.d1);       else n_pass++;
            n_tot++; if (s_d2 !== e.d2)   $display("FAIL alloc#%0d rd2 got %h exp %h", i, s_d2, e.d2);       else n_pass++;
            n_tot++; if (s_fa !== e.fa)   $display("FAIL alloc#%0d free got %0d exp %0d", i, s_fa, e.fa);    else n_pass++;
            n_tot++; if (s_err !== e.err) $display("FAIL alloc#%0d err got %h exp %h", i, s_err, e.err);     else n_pass++;
        end
        n_tot++; if (s_fa !== 10'd2) $display("FAIL alloc_free_final got %0d exp 2", s_fa); else n_pass++;
    endtask

    // A second strobe while a read is in flight must be dropped and flagged.
    task automatic test_busy();
        req(F_GET, 10'd5, 10'd0, 16'h0, 1'b1);
        e = exp_q.pop_front();
        n_tot++; if (s_lat !== e.lat) $display("FAIL busy latency got %0d exp %0d", s_lat, e.lat); else n_pass++;
        n_tot++; if (s_d1 !== e.d1)   $display("FAIL busy rd1 got %h exp %h", s_d1, e.d1);       else n_pass++;
        n_tot++; if (s_d2 !== e.d2)   $display("FAIL busy rd2 got %h exp %h", s_d2, e.d2);       else n_pass++;
        n_tot++; if (s_err !== 8'h01) $display("FAIL busy err got %h exp 01", s_err);            else n_pass++;
        @(negedge clk);
        n_tot++; if (o_rdy !== 1'b0)  $display("FAIL busy_no_extra_ready got %b exp 0", o_rdy); else n_pass++;
    endtask

    task automatic test_nil();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: req(F_SET, 10'd3, 10'd0, 16'h3333, 1'b0);
                1: req(F_GET, NIL, 10'd3, 16'h0, 1'b0);
                2: req(F_SET, NIL, 10'd0, 16'hDEAD, 1'b0);
                default: req(F_GET, 10'd5, 10'd3, 16'h0, 1'b0);
            endcase
            e = exp_q.pop_front();
            n_tot++; if (s_lat !== e.lat) $display("FAIL nil#%0d latency got %0d exp %0d", i, s_lat, e.lat); else n_pass++;
            n_tot++; if (s_d1 !== e.d1)   $display("FAIL nil#%0d rd1 got %h exp %h", i, s_d1, e.d1);       else n_pass++;
            n_tot++; if (s_d2 !== e.d2)   $display("FAIL nil#%0d rd2 got %h exp %h", i, s_d2, e.d2);       else n_pass++;
            n_tot++; if (s_err !== e.err) $display("FAIL nil#%0d err got %h exp %h", i, s_err, e.err);     else n_pass++;
        end
    endtask

    task automatic test_alloc_full();
        sel_hi = 1'b1;
        do_reset(10'd1022);
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: req(F_FREE, 10'd0, 10'd0, 16'h7777, 1'b0);
                1: req(F_FREE, 10'd0, 10'd0, 16'h8888, 1'b0);
                default: req(F_GET, 10'd1022, NIL, 16'h0, 1'b0);
            endcase
            e = exp_q.pop_front();
            n_tot++; if (s_lat !== e.lat) $display("FAIL full#%0d latency got %0d exp %0d", i, s_lat, e.lat); else n_pass++;
            n_tot++; if (s_d1 !== e.d1)   $display("FAIL full#%0d rd1 got %h exp %h", i, s_d1, e.d1);       else n_pass++;
            n_tot++; if (s_d2 !== e.d2)   $display("FAIL full#%0d rd2 got %h exp %h", i, s_d2, e.d2);       else n_pass++;
            n_tot++; if (s_fa !== e.fa)   $display("FAIL full#%0d free got %0d exp %0d", i, s_fa, e.fa);    else n_pass++;
            n_tot++; if (s_err !== e.err) $display("FAIL full#%0d err got %h exp %h", i, s_err, e.err);     else n_pass++;
        end
        sel_hi = 1'b0;
    endtask

    // Reset asserted between a write capture and its completing edge.
    task automatic test_reset_abort();
        bit any_rdy;
        do_reset('0);
        req(F_SET, 10'd7, 10'd0, 16'h1111, 1'b0);
        void'(exp_q.pop_front());
        req(F_GET, 10'd7, 10'd7, 16'h0, 1'b0);
        e = exp_q.pop_front();
        n_tot++; if (s_d1 !== e.d1) $display("FAIL abort_pre rd1 got %h exp %h", s_d1, e.d1); else n_pass++;
        exec = 1'b1; func = F_SET; a1 = 10'd7; wd = 16'h2222;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; exec = 1'b0; func = '0; a1 = '0; wd = '0;
        any_rdy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            any_rdy |= o_rdy;
        end
        n_tot++; if (any_rdy !== 1'b0) $display("FAIL abort_rdy got %b exp 0", any_rdy); else n_pass++;
        n_tot++; if (o_d1 !== '0)      $display("FAIL abort_rd1 got %h exp 0", o_d1);   else n_pass++;
        n_tot++; if (o_d2 !== '0)      $display("FAIL abort_rd2 got %h exp 0", o_d2);   else n_pass++;
        n_tot++; if (o_fa !== '0)      $display("FAIL abort_free got %0d exp 0", o_fa); else n_pass++;
        n_tot++; if (o_err !== 8'h00)  $display("FAIL abort_err got %h exp 00", o_err); else n_pass++;
        rst = 1'b1;
        m_d1 = '0; m_d2 = '0; m_fa = '0; m_err = '0;
        @(negedge clk);
        req(F_GET, 10'd7, 10'd7, 16'h0, 1'b0);
        e = exp_q.pop_front();
        n_tot++; if (s_d1 !== e.d1) $display("FAIL abort_post rd1 got %h exp %h", s_d1, e.d1); else n_pass++;
        n_tot++; if (s_d2 !== 16'h1111) $display("FAIL abort_post rd2 got %h exp 1111", s_d2); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_alloc();
        test_busy();
        test_nil();
        test_alloc_full();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
